jelly_bean_arbiter: RTL and testbench

//  Shares one jelly_bean_if slave (master_mp side) among NUM_REQ requesters. Round-robin

---
 rtl/jelly_bean_if.sv | 14 +
 rtl/jelly_bean_arbiter.sv | 198 +++++++++++++++++++
 tb/tb_jelly_bean_arbiter.sv | 322 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/jelly_bean_if.sv
// Jelly-bean bus between one master (the arbiter) and one slave.
// A transaction is issued by a non-NO_OP command held for exactly one cycle; the slave
// completes it by driving a non-zero taste on any later cycle while the master waits.
interface jelly_bean_if;
    logic [2:0] flavor;
    logic [1:0] color;
    logic       sugar_free;
    logic       sour;
    logic [1:0] command;
    logic [1:0] taste;

    modport master_mp (output flavor, color, sugar_free, sour, command, input taste);
    modport slave_mp  (input flavor, color, sugar_free, sour, command, output taste);
endinterface

// File: rtl/jelly_bean_arbiter.sv
// Round-robin arbiter sharing one jelly_bean_if slave among NUM_REQ requesters.
// Optional WAIT-state abort is enabled by defining JELLY_BEAN_ARB_TIMEOUT_EN.
module jelly_bean_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int TIMEOUT = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [3*NUM_REQ-1:0]   req_flavor,
    input  logic [2*NUM_REQ-1:0]   req_color,
    input  logic [NUM_REQ-1:0]     req_sugar_free,
    input  logic [NUM_REQ-1:0]     req_sour,
    input  logic [2*NUM_REQ-1:0]   req_command,
    output logic [NUM_REQ-1:0]     gnt,
    output logic [NUM_REQ-1:0]     done,
    output logic [1:0]             rsp_taste,
    output logic                   rsp_err,
    output logic [1:0]             dbg_state_o,
    jelly_bean_if.master_mp        bus
);
    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [NUM_REQ-1:0]   gnt_q, gnt_d;
    logic [NUM_REQ-1:0]   done_q, done_d;
    logic [1:0]           rsp_taste_q, rsp_taste_d;
    logic                 rsp_err_q, rsp_err_d;
    logic [IW-1:0]        ptr_q, ptr_d;
    logic [IW-1:0]        win_q, win_d;
    logic [2:0]           flavor_q, flavor_d;
    logic [1:0]           color_q, color_d;
    logic                 sf_q, sf_d;
    logic                 sour_q, sour_d;
    logic [1:0]           cmd_q, cmd_d;
`ifdef JELLY_BEAN_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0]        tmo_q, tmo_d;
`endif

    logic                 pick_valid;
    logic [IW-1:0]        pick_idx;
    logic [NUM_REQ-1:0]   pick_onehot;
    logic [2:0]           pick_flavor;
    logic [1:0]           pick_color;
    logic                 pick_sf;
    logic                 pick_sour;
    logic [1:0]           pick_cmd;

    // Scan downward so the requester closest to ptr (searching upward with wrap) wins last.
    always_comb begin : pick_c
        pick_valid  = 1'b0;
        pick_idx    = '0;
        pick_onehot = '0;
        pick_flavor = '0;
        pick_color  = '0;
        pick_sf     = 1'b0;
        pick_sour   = 1'b0;
        pick_cmd    = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req[IW'((int'(ptr_q) + k) % NUM_REQ)]) begin
                pick_valid = 1'b1;
                pick_idx   = IW'((int'(ptr_q) + k) % NUM_REQ);
            end
        end
        for (int k = 0; k < NUM_REQ; k++) begin
            if (IW'(k) == pick_idx) begin
                pick_onehot[k] = 1'b1;
                pick_flavor    = req_flavor[3*k +: 3];
                pick_color     = req_color[2*k +: 2];
                pick_sf        = req_sugar_free[k];
                pick_sour      = req_sour[k];
                pick_cmd       = req_command[2*k +: 2];
            end
        end
    end

    always_comb begin : fsm_c
        state_d     = state_q;
        gnt_d       = gnt_q;
        done_d      = '0;
        rsp_taste_d = rsp_taste_q;
        rsp_err_d   = rsp_err_q;
        ptr_d       = ptr_q;
        win_d       = win_q;
        flavor_d    = flavor_q;
        color_d     = color_q;
        sf_d        = sf_q;
        sour_d      = sour_q;
        cmd_d       = cmd_q;
`ifdef JELLY_BEAN_ARB_TIMEOUT_EN
        tmo_d       = tmo_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (pick_valid) begin
                    state_d  = S_ISSUE;
                    gnt_d    = pick_onehot;
                    win_d    = pick_idx;
                    flavor_d = pick_flavor;
                    color_d  = pick_color;
                    sf_d     = pick_sf;
                    sour_d   = pick_sour;
                    cmd_d    = pick_cmd;
                end
            end
            S_ISSUE: begin
                state_d  = S_WAIT;
                flavor_d = '0;
                color_d  = '0;
                sf_d     = 1'b0;
                sour_d   = 1'b0;
                cmd_d    = 2'd0;
`ifdef JELLY_BEAN_ARB_TIMEOUT_EN
                tmo_d    = '0;
`endif
            end
            S_WAIT: begin
                if (bus.taste != 2'd0) begin
                    state_d     = S_RESP;
                    done_d      = gnt_q;
                    rsp_taste_d = bus.taste;
                    rsp_err_d   = 1'b0;
                end
`ifdef JELLY_BEAN_ARB_TIMEOUT_EN
                else if (tmo_q == TW'(TIMEOUT - 1)) begin
                    state_d     = S_RESP;
                    done_d      = gnt_q;
                    rsp_taste_d = 2'd0;
                    rsp_err_d   = 1'b1;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
`endif
            end
            S_RESP: begin
                state_d = S_IDLE;
                gnt_d   = '0;
                ptr_d   = (int'(win_q) == NUM_REQ - 1) ? '0 : win_q + 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            gnt_q       <= '0;
            done_q      <= '0;
            rsp_taste_q <= '0;
            rsp_err_q   <= 1'b0;
            ptr_q       <= '0;
            win_q       <= '0;
            flavor_q    <= '0;
            color_q     <= '0;
            sf_q        <= 1'b0;
            sour_q      <= 1'b0;
            cmd_q       <= '0;
`ifdef JELLY_BEAN_ARB_TIMEOUT_EN
            tmo_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            done_q      <= done_d;
            rsp_taste_q <= rsp_taste_d;
            rsp_err_q   <= rsp_err_d;
            ptr_q       <= ptr_d;
            win_q       <= win_d;
            flavor_q    <= flavor_d;
            color_q     <= color_d;
            sf_q        <= sf_d;
            sour_q      <= sour_d;
            cmd_q       <= cmd_d;
`ifdef JELLY_BEAN_ARB_TIMEOUT_EN
            tmo_q       <= tmo_d;
`endif
        end
    end

    assign gnt            = gnt_q;
    assign done           = done_q;
    assign rsp_taste      = rsp_taste_q;
    assign rsp_err        = rsp_err_q;
    assign dbg_state_o    = state_q;
    assign bus.flavor     = flavor_q;
    assign bus.color      = color_q;
    assign bus.sugar_free = sf_q;
    assign bus.sour       = sour_q;
    assign bus.command    = cmd_q;
endmodule

// File: tb/tb_jelly_bean_arbiter.sv
// Self-checking bench for jelly_bean_arbiter; expected completions go through exp_q.
// Build with JELLY_BEAN_ARB_TIMEOUT_EN defined to exercise the abort path instead of the hold path.
module tb_jelly_bean_arbiter;
    localparam int NR = 4;
    localparam int TO = 16;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [NR-1:0]   req;
    logic [3*NR-1:0] req_flavor;
    logic [2*NR-1:0] req_color;
    logic [NR-1:0]   req_sugar_free;
    logic [NR-1:0]   req_sour;
    logic [2*NR-1:0] req_command;
    logic [NR-1:0]   gnt;
    logic [NR-1:0]   done;
    logic [1:0]      rsp_taste;
    logic            rsp_err;
    logic [1:0]      dbg_state;

    jelly_bean_if bus_if ();

    jelly_bean_arbiter #(.NUM_REQ(NR), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .req_flavor(req_flavor), .req_color(req_color),
        .req_sugar_free(req_sugar_free), .req_sour(req_sour), .req_command(req_command),
        .gnt(gnt), .done(done), .rsp_taste(rsp_taste), .rsp_err(rsp_err),
        .dbg_state_o(dbg_state), .bus(bus_if)
    );

    int n_vec = 0;
    int n_err = 0;
    // Expected completion: {winner[2:0], taste[1:0], err}
    logic [5:0] exp_q[$];

    typedef struct {
        bit          got;
        int          issue_cyc;
        int          done_cyc;
        int          cmd_cycles;
        int          flv_cycles;
        logic [NR-1:0] gnt;
        logic [2:0]  flavor;
        logic [1:0]  color;
        logic        sf;
        logic        sour;
        logic [1:0]  cmd;
        logic [NR-1:0] done;
        logic [1:0]  taste;
        logic        err;
    } res_t;

    task automatic set_fields(input int i, input logic [2:0] fl, input logic [1:0] co,
                              input logic sf, input logic so, input logic [1:0] cm);
        req_flavor[3*i +: 3] = fl;
        req_color[2*i +: 2]  = co;
        req_sugar_free[i]    = sf;
        req_sour[i]          = so;
        req_command[2*i +: 2] = cm;
    endtask

    task automatic rand_fields(input int i);
        set_fields(i, 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 2'($urandom_range(1, 3)));
    endtask

    // Slave model: after seeing a command it waits 'delay' cycles (taste 0), then answers tval.
    // Before and during the command cycle it drives 'stale'. Cycle k is the k-th negedge.
    task automatic run_txn(input int budget, input logic [1:0] tval, input logic [1:0] stale,
                           input int delay, input bit drop_req, output res_t r);
        bit armed  = 1'b0;
        int waited = 0;
        r = '{default: 0};
        bus_if.taste = stale;
        for (int k = 1; k <= budget; k++) begin
            @(negedge clk);
            if (done != '0) begin
                r.got = 1'b1; r.done_cyc = k; r.done = done;
                r.taste = rsp_taste; r.err = rsp_err;
                bus_if.taste = 2'd0;
                break;
            end
            if (bus_if.flavor != 3'd0) r.flv_cycles++;
            if (bus_if.command != 2'd0) begin
                r.cmd_cycles++;
                if (!armed) begin
                    r.issue_cyc = k; r.gnt = gnt; r.flavor = bus_if.flavor; r.color = bus_if.color;
                    r.sf = bus_if.sugar_free; r.sour = bus_if.sour; r.cmd = bus_if.command;
                end
                armed = 1'b1;
                bus_if.taste = stale;
                if (drop_req) req = '0;
            end else if (armed) begin
                if (waited < delay) begin
                    bus_if.taste = 2'd0;
                    waited++;
                end else begin
                    bus_if.taste = tval;
                end
            end else begin
                bus_if.taste = stale;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req = '0; req_flavor = '0; req_color = '0; req_sugar_free = '0;
        req_sour = '0; req_command = '0; bus_if.taste = 2'd0;
        repeat (3) @(negedge clk);
        n_vec++; if (gnt !== '0) begin n_err++; $display("FAIL rst_gnt: got %b exp 0", gnt); end
        n_vec++; if (done !== '0) begin n_err++; $display("FAIL rst_done: got %b exp 0", done); end
        n_vec++; if (bus_if.command !== 2'd0 || bus_if.flavor !== 3'd0)
            begin n_err++; $display("FAIL rst_bus: cmd %0d flavor %0d exp 0/0", bus_if.command, bus_if.flavor); end
        n_vec++; if ({rsp_taste, rsp_err} !== 3'b000)
            begin n_err++; $display("FAIL rst_rsp: got %0d/%0d exp 0/0", rsp_taste, rsp_err); end
        n_vec++; if (dbg_state !== 2'd0) begin n_err++; $display("FAIL rst_state: got %0d exp 0", dbg_state); end
        rst_n = 1'b1;
        @(negedge clk);
        set_fields(1, 3'd5, 2'd2, 1'b1, 1'b0, 2'd2);
        req = 4'b0010;
        @(negedge clk);
        @(negedge clk);
        n_vec++; if (gnt !== 4'b0010 || dbg_state !== 2'd2)
            begin n_err++; $display("FAIL pre_abort: gnt %b state %0d exp 0010/2", gnt, dbg_state); end
        #2 rst_n = 1'b0;
        #1;
        n_vec++; if (gnt !== '0 || done !== '0 || bus_if.command !== 2'd0 || dbg_state !== 2'd0)
            begin n_err++; $display("FAIL abort: gnt %b done %b cmd %0d state %0d exp all 0", gnt, done, bus_if.command, dbg_state); end
        @(negedge clk);
        rst_n = 1'b1;
        req = '0;
        begin
            bit seen = 1'b0;
            repeat (10) begin
                @(negedge clk);
                if (done != '0) seen = 1'b1;
            end
            n_vec++; if (seen !== 1'b0) begin n_err++; $display("FAIL abort_no_done: got %b exp 0", seen); end
        end
    endtask

    task automatic test_single();
        res_t r;
        logic [5:0] e;
        set_fields(2, 3'd1, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 2'd1);
        req = 4'b0100;
        exp_q.push_back({3'd2, 2'd1, 1'b0});
        run_txn(20, 2'd1, 2'd0, 0, 1'b0, r);
        req = '0;
        n_vec++; if (r.got !== 1'b1) begin n_err++; $display("FAIL single_got: got %b exp 1", r.got); end
        n_vec++; if (r.issue_cyc != 1) begin n_err++; $display("FAIL single_issue_cyc: got %0d exp 1", r.issue_cyc); end
        n_vec++; if (r.gnt !== 4'b0100) begin n_err++; $display("FAIL single_gnt: got %b exp 0100", r.gnt); end
        n_vec++; if (r.flavor !== 3'd1 || r.cmd !== 2'd1 || r.color !== req_color[5:4])
            begin n_err++; $display("FAIL single_fields: fl %0d cmd %0d col %0d exp 1/1/%0d", r.flavor, r.cmd, r.color, req_color[5:4]); end
        n_vec++; if (r.cmd_cycles != 1 || r.flv_cycles != 1)
            begin n_err++; $display("FAIL single_bus_len: cmd %0d flavor %0d cycles exp 1/1", r.cmd_cycles, r.flv_cycles); end
        n_vec++; if (r.done_cyc != 3) begin n_err++; $display("FAIL single_done_cyc: got %0d exp 3", r.done_cyc); end
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_vec++; if (r.done !== (4'b0001 << e[5:3]) || r.taste !== e[2:1] || r.err !== e[0])
                begin n_err++; $display("FAIL single_sb: done %b taste %0d err %0d exp w%0d t%0d e%0d", r.done, r.taste, r.err, e[5:3], e[2:1], e[0]); end
        end
        @(negedge clk);
        n_vec++; if (done !== '0 || gnt !== '0)
            begin n_err++; $display("FAIL single_after: done %b gnt %b exp 0/0", done, gnt); end
    endtask

    task automatic test_ptr_wrap();
        res_t r;
        logic [5:0] e;
        rand_fields(0);
        rand_fields(3);
        req = 4'b1001;
        exp_q.push_back({3'd3, 2'd2, 1'b0});
        run_txn(20, 2'd2, 2'd0, 0, 1'b0, r);
        req[3] = 1'b0;
        n_vec++; if (r.gnt !== 4'b1000) begin n_err++; $display("FAIL wrap_gnt3: got %b exp 1000", r.gnt); end
        n_vec++; if (r.flavor !== req_flavor[11:9] || r.cmd !== req_command[7:6] || r.sour !== req_sour[3])
            begin n_err++; $display("FAIL wrap_fields3: fl %0d cmd %0d exp %0d/%0d", r.flavor, r.cmd, req_flavor[11:9], req_command[7:6]); end
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_vec++; if (!r.got || r.done !== (4'b0001 << e[5:3]) || r.taste !== e[2:1] || r.err !== e[0])
                begin n_err++; $display("FAIL wrap_sb3: done %b taste %0d exp w%0d t%0d", r.done, r.taste, e[5:3], e[2:1]); end
        end
        exp_q.push_back({3'd0, 2'd1, 1'b0});
        run_txn(20, 2'd1, 2'd0, 0, 1'b0, r);
        req = '0;
        n_vec++; if (r.gnt !== 4'b0001) begin n_err++; $display("FAIL wrap_gnt0: got %b exp 0001", r.gnt); end
        n_vec++; if (r.issue_cyc < 2) begin n_err++; $display("FAIL b2b_gap: issue %0d cycles after done, need >=2", r.issue_cyc); end
        n_vec++; if (r.flavor !== req_flavor[2:0] || r.sf !== req_sugar_free[0])
            begin n_err++; $display("FAIL wrap_fields0: fl %0d exp %0d", r.flavor, req_flavor[2:0]); end
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_vec++; if (!r.got || r.done !== (4'b0001 << e[5:3]) || r.taste !== e[2:1] || r.err !== e[0])
                begin n_err++; $display("FAIL wrap_sb0: done %b taste %0d exp w%0d t%0d", r.done, r.taste, e[5:3], e[2:1]); end
        end
    endtask

    task automatic test_all_req();
        res_t r;
        logic [5:0] e;
        int order[5] = '{0, 1, 2, 3, 0};
        int dcnt[NR] = '{default: 0};
        bit once_ok;
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < NR; i++) rand_fields(i);
        req = 4'b1111;
        for (int j = 0; j < 5; j++) begin
            exp_q.push_back({3'(order[j]), 2'd2, 1'b0});
            run_txn(20, 2'd2, 2'd0, 0, 1'b0, r);
            n_vec++; if (r.gnt !== (4'b0001 << order[j]))
                begin n_err++; $display("FAIL all_gnt[%0d]: got %b exp %b", j, r.gnt, 4'b0001 << order[j]); end
            n_vec++; if (r.flavor !== req_flavor[3*order[j] +: 3] || r.color !== req_color[2*order[j] +: 2])
                begin n_err++; $display("FAIL all_fields[%0d]: fl %0d col %0d", j, r.flavor, r.color); end
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_vec++; if (!r.got || r.done !== (4'b0001 << e[5:3]) || r.taste !== e[2:1] || r.err !== e[0])
                    begin n_err++; $display("FAIL all_sb[%0d]: done %b taste %0d exp w%0d t%0d", j, r.done, r.taste, e[5:3], e[2:1]); end
            end
            if (j < 4) for (int i = 0; i < NR; i++) if (r.done[i]) dcnt[i]++;
        end
        req = '0;
        once_ok = 1'b1;
        for (int i = 0; i < NR; i++) if (dcnt[i] != 1) once_ok = 1'b0;
        n_vec++; if (once_ok !== 1'b1)
            begin n_err++; $display("FAIL all_done_once: counts %0d %0d %0d %0d exp 1 each", dcnt[0], dcnt[1], dcnt[2], dcnt[3]); end
    endtask

    task automatic test_timeout();
        res_t r;
        logic [5:0] e;
        rand_fields(1);
        req = 4'b0010;
`ifdef JELLY_BEAN_ARB_TIMEOUT_EN
        exp_q.push_back({3'd1, 2'd0, 1'b1});
        run_txn(60, 2'd0, 2'd0, 1000, 1'b0, r);
        req = '0;
        n_vec++; if (r.issue_cyc != 1 || r.done_cyc != TO + 2)
            begin n_err++; $display("FAIL tmo_cyc: issue %0d done %0d exp 1/%0d", r.issue_cyc, r.done_cyc, TO + 2); end
`else
        run_txn(100, 2'd1, 2'd0, 1000, 1'b0, r);
        n_vec++; if (r.got !== 1'b0) begin n_err++; $display("FAIL hold_no_done: got done at %0d exp none", r.done_cyc); end
        n_vec++; if (dbg_state !== 2'd2 || gnt !== 4'b0010)
            begin n_err++; $display("FAIL hold_state: state %0d gnt %b exp 2/0010", dbg_state, gnt); end
        exp_q.push_back({3'd1, 2'd1, 1'b0});
        bus_if.taste = 2'd1;
        r.got = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            if (done != '0) begin
                r.got = 1'b1; r.done_cyc = k; r.done = done; r.taste = rsp_taste; r.err = rsp_err;
                break;
            end
        end
        bus_if.taste = 2'd0;
        req = '0;
        n_vec++; if (r.done_cyc != 1) begin n_err++; $display("FAIL hold_done_cyc: got %0d exp 1", r.done_cyc); end
`endif
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_vec++; if (!r.got || r.done !== (4'b0001 << e[5:3]) || r.taste !== e[2:1] || r.err !== e[0])
                begin n_err++; $display("FAIL tmo_sb: got %b done %b taste %0d err %0d exp t%0d e%0d", r.got, r.done, r.taste, r.err, e[2:1], e[0]); end
        end
    endtask

    task automatic test_stale();
        res_t r;
        logic [5:0] e;
        bit idle_ok = 1'b1;
        req = '0;
        bus_if.taste = 2'd1;
        repeat (3) begin
            @(negedge clk);
            if (gnt !== '0 || done !== '0 || dbg_state !== 2'd0) idle_ok = 1'b0;
        end
        n_vec++; if (idle_ok !== 1'b1) begin n_err++; $display("FAIL stale_idle: got %b exp 1", idle_ok); end
        rand_fields(3);
        req = 4'b1000;
        exp_q.push_back({3'd3, 2'd2, 1'b0});
        // Requester drops req on the command cycle; the transaction must still complete.
        run_txn(30, 2'd2, 2'd1, 2, 1'b1, r);
        n_vec++; if (r.issue_cyc != 1 || r.done_cyc != 5)
            begin n_err++; $display("FAIL stale_cyc: issue %0d done %0d exp 1/5", r.issue_cyc, r.done_cyc); end
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_vec++; if (!r.got || r.done !== (4'b0001 << e[5:3]) || r.taste !== e[2:1] || r.err !== e[0])
                begin n_err++; $display("FAIL stale_sb: done %b taste %0d exp w%0d t%0d", r.done, r.taste, e[5:3], e[2:1]); end
        end
        rand_fields(0);
        req = 4'b0001;
        exp_q.push_back({3'd0, 2'd3, 1'b0});
        run_txn(20, 2'd3, 2'd0, 0, 1'b0, r);
        req = '0;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_vec++; if (!r.got || r.done !== (4'b0001 << e[5:3]) || r.taste !== e[2:1] || r.err !== e[0])
                begin n_err++; $display("FAIL taste3_sb: done %b taste %0d exp w%0d t%0d", r.done, r.taste, e[5:3], e[2:1]); end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_ptr_wrap();
        test_all_req();
        test_timeout();
        test_stale();
        n_vec++; if (exp_q.size() != 0) begin n_err++; $display("FAIL sb_leftover: %0d entries exp 0", exp_q.size()); end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end
endmodule
